// File: rtl/uart_rx_param.sv
// Parametrised oversampling UART receiver: synchronised input, start-bit glitch
// rejection, configurable width/parity/stop bits, parity/framing flags and break hold-off.
module uart_rx_param #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 P_CLK,
    input  logic                 reset,
    input  logic                 i_RX,
    input  logic                 i_TICK,
    output logic [DATA_BITS-1:0] o_RX_DATA,
    output logic                 o_RX_VALID,
    output logic                 o_PARITY_ERR,
    output logic                 o_FRAME_ERR,
    output logic                 o_BUSY,
    output logic [2:0]           dbg_state
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

    // dbg_state encoding: 0 IDLE, 1 START, 2 DATA, 3 PARITY, 4 STOP, 5 BREAK
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
    } state_t;

    state_t                 state, state_n;
    logic                   rx_meta, rx_s;
    logic [TW-1:0]          tick_cnt, tick_n;
    logic [BW-1:0]          bit_cnt, bit_n;
    logic [DATA_BITS-1:0]   shreg, shreg_n;
    logic                   par_acc, par_n;
    logic                   perr, perr_n;
    logic                   ferr, ferr_n;
    logic                   commit;

    assign dbg_state = state;

    always_ff @(posedge P_CLK or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= i_RX;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge P_CLK or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            par_acc  <= 1'b0;
            perr     <= 1'b0;
            ferr     <= 1'b0;
        end else begin
            state    <= state_n;
            tick_cnt <= tick_n;
            bit_cnt  <= bit_n;
            shreg    <= shreg_n;
            par_acc  <= par_n;
            perr     <= perr_n;
            ferr     <= ferr_n;
        end
    end

    always_comb begin
        state_n = state;
        tick_n  = tick_cnt;
        bit_n   = bit_cnt;
        shreg_n = shreg;
        par_n   = par_acc;
        perr_n  = perr;
        ferr_n  = ferr;
        commit  = 1'b0;
        case (state)
            S_IDLE: begin
                if (!rx_s) begin
                    state_n = S_START;
                    tick_n  = '0;
                end
            end
            S_START: begin
                if (i_TICK) begin
                    if (tick_cnt == TICK_MID) begin
                        // A line that is high again at mid start bit was only a glitch.
                        if (rx_s) begin
                            state_n = S_IDLE;
                        end else begin
                            state_n = S_DATA;
                            tick_n  = '0;
                            bit_n   = '0;
                            par_n   = 1'b0;
                            perr_n  = 1'b0;
                            ferr_n  = 1'b0;
                        end
                    end else begin
                        tick_n = tick_cnt + 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (i_TICK) begin
                    if (tick_cnt == TICK_LAST) begin
                        tick_n  = '0;
                        shreg_n = {rx_s, shreg[DATA_BITS-1:1]};
                        par_n   = par_acc ^ rx_s;
                        if (bit_cnt == BIT_LAST) begin
                            bit_n   = '0;
                            state_n = (PARITY != 0) ? S_PARITY : S_STOP;
                        end else begin
                            bit_n = bit_cnt + 1'b1;
                        end
                    end else begin
                        tick_n = tick_cnt + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (i_TICK) begin
                    if (tick_cnt == TICK_LAST) begin
                        tick_n  = '0;
                        bit_n   = '0;
                        perr_n  = (PARITY == 1) ? ~(par_acc ^ rx_s) : (par_acc ^ rx_s);
                        state_n = S_STOP;
                    end else begin
                        tick_n = tick_cnt + 1'b1;
                    end
                end
            end
            S_STOP: begin
                if (i_TICK) begin
                    if (tick_cnt == TICK_LAST) begin
                        tick_n = '0;
                        ferr_n = ferr | ~rx_s;
                        if (bit_cnt == STOP_LAST) begin
                            commit  = 1'b1;
                            bit_n   = '0;
                            state_n = rx_s ? S_IDLE : S_BREAK;
                        end else begin
                            bit_n = bit_cnt + 1'b1;
                        end
                    end else begin
                        tick_n = tick_cnt + 1'b1;
                    end
                end
            end
            S_BREAK: begin
                if (rx_s) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Flags take ferr_n so the final stop sample is included in the same commit.
    always_ff @(posedge P_CLK or posedge reset) begin
        if (reset) begin
            o_RX_DATA    <= '0;
            o_RX_VALID   <= 1'b0;
            o_PARITY_ERR <= 1'b0;
            o_FRAME_ERR  <= 1'b0;
            o_BUSY       <= 1'b0;
        end else begin
            o_RX_VALID <= commit;
            o_BUSY     <= (state_n != S_IDLE);
            if (commit) begin
                o_RX_DATA    <= shreg;
                o_PARITY_ERR <= perr;
                o_FRAME_ERR  <= ferr_n;
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: three configurations (8N1, 8E1, 7O2) share clock, reset and
// tick; frames are built bit by bit and checked against a frame-level reference model.
module tb_uart_rx_param;
    localparam int OS = 16;

    logic P_CLK = 1'b0;
    logic reset = 1'b1;
    logic tick  = 1'b0;
    logic rx_a  = 1'b1;
    logic rx_b  = 1'b1;
    logic rx_c  = 1'b1;

    logic [7:0] data_a, data_b;
    logic [6:0] data_c;
    logic valid_a, perr_a, ferr_a, busy_a;
    logic valid_b, perr_b, ferr_b, busy_b;
    logic valid_c, perr_c, ferr_c, busy_c;
    logic [2:0] state_a, state_b, state_c;

    int checks  = 0;
    int errors  = 0;
    int max_gap = 0;

    // Words are packed as {parity_err, frame_err, data[7:0]}.
    logic [9:0] exp_q[$];
    logic [9:0] obs_a[$], obs_b[$], obs_c[$];

    always #5 P_CLK = ~P_CLK;

    uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(OS), .PARITY(0), .STOP_BITS(1)) dut_a (
        .P_CLK(P_CLK), .reset(reset), .i_RX(rx_a), .i_TICK(tick),
        .o_RX_DATA(data_a), .o_RX_VALID(valid_a), .o_PARITY_ERR(perr_a),
        .o_FRAME_ERR(ferr_a), .o_BUSY(busy_a), .dbg_state(state_a));

    uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(OS), .PARITY(2), .STOP_BITS(1)) dut_b (
        .P_CLK(P_CLK), .reset(reset), .i_RX(rx_b), .i_TICK(tick),
        .o_RX_DATA(data_b), .o_RX_VALID(valid_b), .o_PARITY_ERR(perr_b),
        .o_FRAME_ERR(ferr_b), .o_BUSY(busy_b), .dbg_state(state_b));

    uart_rx_param #(.DATA_BITS(7), .OVERSAMPLE(OS), .PARITY(1), .STOP_BITS(2)) dut_c (
        .P_CLK(P_CLK), .reset(reset), .i_RX(rx_c), .i_TICK(tick),
        .o_RX_DATA(data_c), .o_RX_VALID(valid_c), .o_PARITY_ERR(perr_c),
        .o_FRAME_ERR(ferr_c), .o_BUSY(busy_c), .dbg_state(state_c));

    // Capture every strobe; a strobe held for two cycles shows up as an extra word.
    always @(negedge P_CLK) begin
        if (valid_a) obs_a.push_back({perr_a, ferr_a, data_a});
        if (valid_b) obs_b.push_back({perr_b, ferr_b, data_b});
        if (valid_c) obs_c.push_back({perr_c, ferr_c, 1'b0, data_c});
    end

    function automatic logic [9:0] model(input logic [7:0] d, input int nbits, input int par,
                                         input logic pbit, input logic [1:0] stops,
                                         input int nstop);
        logic [7:0] m;
        int ones;
        logic pe, fe;
        m    = d & 8'((1 << nbits) - 1);
        ones = $countones(m) + int'(pbit);
        if (par == 1)      pe = (ones % 2 == 0);
        else if (par == 2) pe = (ones % 2 == 1);
        else               pe = 1'b0;
        fe = (stops[0] == 1'b0) || (nstop == 2 && stops[1] == 1'b0);
        return {pe, fe, m};
    endfunction

    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(posedge P_CLK);
            #1;
        end
    endtask

    task automatic do_ticks(input int n);
        repeat (n) begin
            wait_cycles($urandom_range(0, max_gap));
            tick = 1'b1;
            wait_cycles(1);
            tick = 1'b0;
        end
    endtask

    task automatic set_line(input int w, input logic v);
        case (w)
            0:       rx_a = v;
            1:       rx_b = v;
            default: rx_c = v;
        endcase
    endtask

    task automatic send_bits(input int w, input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            set_line(w, bits[i]);
            do_ticks(OS);
        end
    endtask

    task automatic test_reset;
        repeat (4) @(posedge P_CLK);
        #1;
        checks++;
        if ({data_a, valid_a, perr_a, ferr_a, busy_a} !== 12'h0) begin
            errors++;
            $display("FAIL reset_a: got %h expected 000", {data_a, valid_a, perr_a, ferr_a, busy_a});
        end
        checks++;
        if ({data_b, valid_b, perr_b, ferr_b, busy_b} !== 12'h0) begin
            errors++;
            $display("FAIL reset_b: got %h expected 000", {data_b, valid_b, perr_b, ferr_b, busy_b});
        end
        checks++;
        if ({data_c, valid_c, perr_c, ferr_c, busy_c} !== 11'h0) begin
            errors++;
            $display("FAIL reset_c: got %h expected 000", {data_c, valid_c, perr_c, ferr_c, busy_c});
        end
        checks++;
        if ({state_a, state_b, state_c} !== 9'h0) begin
            errors++;
            $display("FAIL reset_state: got %h expected 000 (all idle)", {state_a, state_b, state_c});
        end
        reset = 1'b0;
        wait_cycles(5);
        checks++;
        if ({busy_a, busy_b, busy_c, valid_a, valid_b, valid_c} !== 6'h0) begin
            errors++;
            $display("FAIL idle_after_reset: got %b expected 000000",
                     {busy_a, busy_b, busy_c, valid_a, valid_b, valid_c});
        end
    endtask

    task automatic test_8n1;
        logic [7:0] d;
        logic [9:0] e, o;
        max_gap = 1;
        exp_q.delete();
        for (int i = 0; i < 4; i++) begin
            d = (i == 0) ? 8'hA5 : 8'($urandom_range(0, 255));
            exp_q.push_back(model(d, 8, 0, 1'b0, 2'b11, 1));
            send_bits(0, 16'({1'b1, d, 1'b0}), 10);
        end
        wait_cycles(5);
        checks++;
        if (obs_a.size() != exp_q.size()) begin
            errors++;
            $display("FAIL 8n1_count: got %0d strobes expected %0d", obs_a.size(), exp_q.size());
        end
        e = exp_q[exp_q.size() - 1];
        while (exp_q.size() > 0 && obs_a.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_a.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL 8n1_word: got %h expected %h", o, e);
            end
        end
        wait_cycles(20);
        checks++;
        if (busy_a !== 1'b0 || data_a !== e[7:0]) begin
            errors++;
            $display("FAIL 8n1_idle_hold: got busy=%b data=%h expected busy=0 data=%h",
                     busy_a, data_a, e[7:0]);
        end
    endtask

    task automatic test_8e1_parity;
        logic [7:0] d;
        logic p;
        logic [9:0] e, o;
        max_gap = 2;
        exp_q.delete();
        for (int i = 0; i < 5; i++) begin
            d = (i < 2) ? 8'h3C : 8'($urandom_range(0, 255));
            p = (i == 0) ? 1'b1 : (i == 1) ? 1'b0 : 1'($urandom_range(0, 1));
            exp_q.push_back(model(d, 8, 2, p, 2'b11, 1));
            send_bits(1, 16'({1'b1, p, d, 1'b0}), 11);
        end
        wait_cycles(5);
        checks++;
        if (obs_b.size() != exp_q.size()) begin
            errors++;
            $display("FAIL 8e1_count: got %0d strobes expected %0d", obs_b.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_b.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_b.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL 8e1_word: got %h expected %h", o, e);
            end
        end
    endtask

    task automatic test_frame_break;
        logic [9:0] e, o;
        max_gap = 1;
        e = model(8'h55, 8, 0, 1'b0, 2'b10, 1);
        send_bits(0, 16'({1'b0, 8'h55, 1'b0}), 10);
        do_ticks(3 * OS);
        checks++;
        if (busy_a !== 1'b1) begin
            errors++;
            $display("FAIL break_busy: got %b expected 1", busy_a);
        end
        checks++;
        if (obs_a.size() != 1) begin
            errors++;
            $display("FAIL break_count: got %0d strobes expected 1", obs_a.size());
        end
        if (obs_a.size() > 0) begin
            o = obs_a.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL break_word: got %h expected %h", o, e);
            end
        end
        set_line(0, 1'b1);
        for (int i = 0; i < 10 && busy_a; i++) wait_cycles(1);
        checks++;
        if (busy_a !== 1'b0 || obs_a.size() != 0) begin
            errors++;
            $display("FAIL break_exit: got busy=%b extra=%0d expected busy=0 extra=0",
                     busy_a, obs_a.size());
        end
    endtask

    task automatic test_glitch;
        logic [9:0] saved;
        max_gap = 2;
        saved = {perr_a, ferr_a, data_a};
        set_line(0, 1'b0);
        do_ticks(4);
        checks++;
        if (busy_a !== 1'b1) begin
            errors++;
            $display("FAIL glitch_busy_rise: got %b expected 1", busy_a);
        end
        set_line(0, 1'b1);
        do_ticks(2 * OS);
        wait_cycles(3);
        checks++;
        if (busy_a !== 1'b0 || obs_a.size() != 0 || {perr_a, ferr_a, data_a} !== saved) begin
            errors++;
            $display("FAIL glitch_reject: got busy=%b strobes=%0d out=%h expected busy=0 strobes=0 out=%h",
                     busy_a, obs_a.size(), {perr_a, ferr_a, data_a}, saved);
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] d;
        logic p, s0;
        logic [9:0] e, o;
        max_gap = 3;
        exp_q.delete();
        for (int i = 0; i < 5; i++) begin
            d  = (i == 0) ? 8'h7F : (i == 1) ? 8'h01 : 8'($urandom_range(0, 127));
            p  = (i < 2) ? ~(^d[6:0]) : 1'($urandom_range(0, 1));
            s0 = (i < 2) ? 1'b1 : 1'($urandom_range(0, 1));
            exp_q.push_back(model(d, 7, 1, p, {1'b1, s0}, 2));
            send_bits(2, 16'({1'b1, s0, p, d[6:0], 1'b0}), 11);
        end
        wait_cycles(5);
        checks++;
        if (obs_c.size() != exp_q.size()) begin
            errors++;
            $display("FAIL 7o2_count: got %0d strobes expected %0d", obs_c.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_c.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_c.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL 7o2_word: got %h expected %h", o, e);
            end
        end
    endtask

    task automatic test_reset_midframe;
        logic [9:0] e, o;
        max_gap = 1;
        send_bits(0, 16'h001E, 5);
        set_line(0, 1'b1);
        do_ticks(OS / 2);
        checks++;
        if (busy_a !== 1'b1) begin
            errors++;
            $display("FAIL midframe_busy: got %b expected 1", busy_a);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({data_a, valid_a, perr_a, ferr_a, busy_a} !== 12'h0) begin
            errors++;
            $display("FAIL midframe_reset_out: got %h expected 000",
                     {data_a, valid_a, perr_a, ferr_a, busy_a});
        end
        wait_cycles(3);
        reset = 1'b0;
        do_ticks(2 * OS);
        checks++;
        if (obs_a.size() != 0 || busy_a !== 1'b0) begin
            errors++;
            $display("FAIL midframe_no_word: got strobes=%0d busy=%b expected 0 0", obs_a.size(), busy_a);
        end
        e = model(8'h12, 8, 0, 1'b0, 2'b11, 1);
        send_bits(0, 16'({1'b1, 8'h12, 1'b0}), 10);
        wait_cycles(5);
        checks++;
        if (obs_a.size() != 1) begin
            errors++;
            $display("FAIL after_reset_count: got %0d strobes expected 1", obs_a.size());
        end
        if (obs_a.size() > 0) begin
            o = obs_a.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL after_reset_word: got %h expected %h", o, e);
            end
        end
    endtask

    initial begin
        test_reset;
        test_8n1;
        test_8e1_parity;
        test_frame_break;
        test_glitch;
        test_back_to_back;
        test_reset_midframe;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule
